// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// mul_div_unit : iterative signed/unsigned multiply/divide with HI/LO registers
// Revision     : 1.0
// ============================================================================
module mul_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_cancel,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_data_1,
   input  logic [WIDTH-1:0] i_data_2,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_div_by_zero
);

   localparam logic [2:0] c_op_mult  = 3'b000;
   localparam logic [2:0] c_op_multu = 3'b001;
   localparam logic [2:0] c_op_div   = 3'b010;
   localparam logic [2:0] c_op_divu  = 3'b011;
   localparam logic [2:0] c_op_mthi  = 3'b100;
   localparam logic [2:0] c_op_mtlo  = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_rem;
   logic [WIDTH-1:0]     r_opnd;
   logic                 r_is_div;
   logic                 r_neg_res;
   logic                 r_neg_rem;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic                 r_done;
   logic                 r_dbz;

   logic                 w_req;
   logic                 w_is_mul;
   logic                 w_is_div;
   logic                 w_signed;
   logic                 w_div_zero;
   logic                 w_accept;
   logic                 w_neg_1;
   logic                 w_neg_2;
   logic [WIDTH-1:0]     w_mag_1;
   logic [WIDTH-1:0]     w_mag_2;
   logic [WIDTH:0]       w_mul_sum;
   logic [WIDTH:0]       w_rem_shift;
   logic [WIDTH:0]       w_rem_diff;
   logic                 w_rem_ge;
   logic [2*WIDTH-1:0]   w_prod_fix;
   logic [WIDTH-1:0]     w_quo_fix;
   logic [WIDTH-1:0]     w_rem_fix;

   assign w_req      = i_start && !i_cancel && (r_state == S_IDLE);
   assign w_is_mul   = (i_op == c_op_mult) || (i_op == c_op_multu);
   assign w_is_div   = (i_op == c_op_div)  || (i_op == c_op_divu);
   assign w_signed   = !i_op[0];
   assign w_div_zero = w_is_div && (i_data_2 == '0);
   assign w_accept   = w_req && (w_is_mul || (w_is_div && !w_div_zero));

   assign w_neg_1 = w_signed && i_data_1[WIDTH-1];
   assign w_neg_2 = w_signed && i_data_2[WIDTH-1];
   assign w_mag_1 = w_neg_1 ? -i_data_1 : i_data_1;
   assign w_mag_2 = w_neg_2 ? -i_data_2 : i_data_2;

   // Shift-add step: conditionally add multiplicand into the upper half, then shift right.
   assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

   // Restoring step: the shifted remainder is below twice the divisor, so the
   // top bit of the difference is a valid sign for the trial subtraction.
   assign w_rem_shift = {r_rem, r_acc[WIDTH-1]};
   assign w_rem_diff  = w_rem_shift - {1'b0, r_opnd};
   assign w_rem_ge    = !w_rem_diff[WIDTH];

   assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
   assign w_quo_fix  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem_fix  = r_neg_rem ? -r_rem : r_rem;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next = S_CALC;
            end
         end
         S_CALC: begin
            if (i_cancel) begin
               w_state_next = S_IDLE;
            end else if (r_cnt == CNT_W'(1)) begin
               w_state_next = S_FIX;
            end
         end
         S_FIX:   w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_rem     <= '0;
         r_opnd    <= '0;
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_done    <= 1'b0;
         r_dbz     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_dbz  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cnt     <= CNT_W'(WIDTH);
                  r_rem     <= '0;
                  r_is_div  <= w_is_div;
                  r_neg_res <= w_neg_1 ^ w_neg_2;
                  r_neg_rem <= w_neg_1;
                  r_opnd    <= w_is_div ? w_mag_2 : w_mag_1;
                  r_acc     <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_1 : w_mag_2)};
               end else if (w_req && w_div_zero) begin
                  r_hi   <= i_data_1;
                  r_lo   <= '1;
                  r_done <= 1'b1;
                  r_dbz  <= 1'b1;
               end else if (w_req && (i_op == c_op_mthi)) begin
                  r_hi <= i_data_1;
               end else if (w_req && (i_op == c_op_mtlo)) begin
                  r_lo <= i_data_1;
               end
            end
            S_CALC: begin
               if (!i_cancel) begin
                  r_cnt <= r_cnt - CNT_W'(1);
                  if (r_is_div) begin
                     r_rem            <= w_rem_ge ? w_rem_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
                     r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], w_rem_ge};
                  end else begin
                     r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                  end
               end
            end
            S_FIX: begin
               if (!i_cancel) begin
                  r_done <= 1'b1;
                  if (r_is_div) begin
                     r_hi <= w_rem_fix;
                     r_lo <= w_quo_fix;
                  end else begin
                     r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                     r_lo <= w_prod_fix[WIDTH-1:0];
                  end
               end
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign o_hi          = r_hi;
   assign o_lo          = r_lo;
   assign o_busy        = (r_state != S_IDLE);
   assign o_done        = r_done;
   assign o_div_by_zero = r_dbz;

endmodule
`default_nettype wire
